// File: rtl/prewish_blinky_multi.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// prewish_blinky_multi
//
// Multi-channel mask blinker. Each channel shifts a MASK_BITS-wide pattern
// out MSB-first to its LED, advancing one bit per shared prescaler tick.
// Masks arrive over a Wishbone-style write strobe. A write to an idle
// channel starts it at once. A write to a running channel is parked in a
// pending buffer and takes effect at the next pattern boundary. Each write
// chooses repeat (MODE_I=1) or one-shot (MODE_I=0) playback.
//
// Ports
//   CLK_I   in   1          system clock
//   RST_I   in   1          synchronous active-high reset
//   STB_I   in   1          write strobe, rising edge performs one write
//   ADR_I   in   CH_BITS    target channel (>= NUM_CH is acked, ignored)
//   DAT_I   in   MASK_BITS  mask to load
//   MODE_I  in   1          1 = repeat pattern, 0 = one-shot
//   ACK_O   out  1          one-cycle acknowledge, the cycle after a write
//   LED_O   out  NUM_CH     active-high LED outputs (registered)
//   BUSY_O  out  NUM_CH     channel is in RUN state
// ---------------------------------------------------------------------------
module prewish_blinky_multi #(
    parameter int NUM_CH        = 4,
    parameter int MASK_BITS     = 8,
    parameter int MASK_CLK_BITS = 14,
    parameter int CH_BITS       = 2
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 STB_I,
    input  logic [CH_BITS-1:0]   ADR_I,
    input  logic [MASK_BITS-1:0] DAT_I,
    input  logic                 MODE_I,
    output logic                 ACK_O,
    output logic [NUM_CH-1:0]    LED_O,
    output logic [NUM_CH-1:0]    BUSY_O
);

    localparam int IDX_W = (MASK_BITS > 1) ? $clog2(MASK_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MASK_BITS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chState_t;

    logic [MASK_CLK_BITS-1:0] r_presc;
    logic                     r_stbD;
    logic                     r_ack;
    logic                     w_tick;
    logic                     w_wr;

    // The tick is the last count of the prescaler, so idx advances on the
    // edge where the prescaler wraps back to zero.
    assign w_tick = &r_presc;
    // A held strobe produces exactly one write; it must drop before the next.
    assign w_wr   = STB_I & ~r_stbD;
    assign ACK_O  = r_ack;

    // Shared prescaler, strobe edge detector and acknowledge register.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_presc <= '0;
            r_stbD  <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_presc <= r_presc + MASK_CLK_BITS'(1);
            r_stbD  <= STB_I;
            r_ack   <= w_wr;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        chState_t             r_state;
        chState_t             w_stateNext;
        logic [MASK_BITS-1:0] r_active;
        logic [MASK_BITS-1:0] w_activeNext;
        logic [MASK_BITS-1:0] r_pending;
        logic [MASK_BITS-1:0] w_pendingNext;
        logic                 r_pendValid;
        logic                 w_pendValidNext;
        logic                 r_pendMode;
        logic                 w_pendModeNext;
        logic                 r_mode;
        logic                 w_modeNext;
        logic [IDX_W-1:0]     r_idx;
        logic [IDX_W-1:0]     w_idxNext;
        logic                 r_led;
        logic                 w_ledNext;
        logic                 w_busy;
        logic                 w_wrCh;

        assign w_wrCh    = w_wr && (ADR_I == CH_BITS'(c));
        assign LED_O[c]  = r_led;
        assign BUSY_O[c] = w_busy;

        // Channel state register; reset discards the pattern and any pending mask.
        always_ff @(posedge CLK_I) begin
            if (RST_I) begin
                r_state     <= ST_IDLE;
                r_active    <= '0;
                r_pending   <= '0;
                r_pendValid <= 1'b0;
                r_pendMode  <= 1'b0;
                r_mode      <= 1'b0;
                r_idx       <= '0;
                r_led       <= 1'b0;
            end else begin
                r_state     <= w_stateNext;
                r_active    <= w_activeNext;
                r_pending   <= w_pendingNext;
                r_pendValid <= w_pendValidNext;
                r_pendMode  <= w_pendModeNext;
                r_mode      <= w_modeNext;
                r_idx       <= w_idxNext;
                r_led       <= w_ledNext;
            end
        end

        // Next-state logic. At a boundary a same-cycle write beats the
        // pending buffer, which beats repeat, which beats going idle.
        always_comb begin
            w_stateNext     = r_state;
            w_activeNext    = r_active;
            w_pendingNext   = r_pending;
            w_pendValidNext = r_pendValid;
            w_pendModeNext  = r_pendMode;
            w_modeNext      = r_mode;
            w_idxNext       = r_idx;
            case (r_state)
                ST_IDLE: begin
                    if (w_wrCh) begin
                        w_activeNext = DAT_I;
                        w_modeNext   = MODE_I;
                        w_idxNext    = '0;
                        w_stateNext  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_tick && (r_idx == LAST_IDX)) begin
                        w_idxNext = '0;
                        if (w_wrCh) begin
                            w_activeNext    = DAT_I;
                            w_modeNext      = MODE_I;
                            w_pendValidNext = 1'b0;
                        end else if (r_pendValid) begin
                            w_activeNext    = r_pending;
                            w_modeNext      = r_pendMode;
                            w_pendValidNext = 1'b0;
                        end else if (!r_mode) begin
                            w_stateNext = ST_IDLE;
                        end
                    end else begin
                        if (w_tick) begin
                            w_idxNext = r_idx + IDX_W'(1);
                        end
                        if (w_wrCh) begin
                            w_pendingNext   = DAT_I;
                            w_pendModeNext  = MODE_I;
                            w_pendValidNext = 1'b1;
                        end
                    end
                end
                default: w_stateNext = ST_IDLE;
            endcase
        end

        // Output logic. The LED is registered from the current idx, so it
        // trails the state/idx update by one clock.
        always_comb begin
            w_busy    = (r_state == ST_RUN);
            w_ledNext = 1'b0;
            if (r_state == ST_RUN) begin
                w_ledNext = r_active[LAST_IDX - r_idx];
            end
        end
    end

endmodule

// File: tb/tb_prewish_blinky_multi.sv
`timescale 1ns/1ps
// Directed bench for prewish_blinky_multi with 2 channels, 8-bit masks and a
// 16-clock bit period. Expected LED/BUSY samples are queued when a write is
// driven and compared mid-bit when the cycle they describe comes around.
module tb_prewish_blinky_multi;

    localparam int NUM_CH        = 2;
    localparam int MASK_BITS     = 8;
    localparam int MASK_CLK_BITS = 4;
    localparam int CH_BITS       = 2;
    localparam int BIT_CLKS      = 16;

    logic        clk = 1'b0;
    logic        RST_I;
    logic        STB_I;
    logic [1:0]  ADR_I;
    logic [7:0]  DAT_I;
    logic        MODE_I;
    logic        ACK_O;
    logic [1:0]  LED_O;
    logic [1:0]  BUSY_O;

    int cyc     = 0;
    int total   = 0;
    int bad     = 0;
    int ackSeen = 0;
    int ackBefore;

    typedef struct {
        int         at;
        logic [1:0] led;
        logic [1:0] busy;
        string      tag;
    } exp_t;

    exp_t sb[$];

    prewish_blinky_multi #(
        .NUM_CH        (NUM_CH),
        .MASK_BITS     (MASK_BITS),
        .MASK_CLK_BITS (MASK_CLK_BITS),
        .CH_BITS       (CH_BITS)
    ) dut (
        .CLK_I  (clk),
        .RST_I  (RST_I),
        .STB_I  (STB_I),
        .ADR_I  (ADR_I),
        .DAT_I  (DAT_I),
        .MODE_I (MODE_I),
        .ACK_O  (ACK_O),
        .LED_O  (LED_O),
        .BUSY_O (BUSY_O)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset edge; equals the expected prescaler count.
    always @(posedge clk) begin
        if (RST_I) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (ACK_O === 1'b1) ackSeen++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h",
                   tag, cyc, observed, expected);
        end
    endtask

    task automatic drainDue();
        exp_t e;
        while (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            checkOutput({e.tag, "_led"},  16'(LED_O),  16'(e.led));
            checkOutput({e.tag, "_busy"}, 16'(BUSY_O), 16'(e.busy));
        end
    endtask

    // Advance to the negedge following edge n, comparing any due samples.
    task automatic stepTo(input int n);
        while (cyc < n) begin
            @(negedge clk);
            drainDue();
        end
    endtask

    task automatic pushPattern(input string tag, input int ch, input int first,
                               input logic [7:0] pat);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.at       = first + BIT_CLKS * k;
            e.led      = 2'b00;
            e.busy     = 2'b00;
            e.led[ch]  = pat[7-k];
            e.busy[ch] = 1'b1;
            e.tag      = $sformatf("%s_b%0d", tag, k);
            sb.push_back(e);
        end
    endtask

    task automatic pushIdle(input string tag, input int at);
        exp_t e;
        e.at   = at;
        e.led  = 2'b00;
        e.busy = 2'b00;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] adr, input logic [7:0] dat,
                                 input logic mode);
        STB_I  = 1'b1;
        ADR_I  = adr;
        DAT_I  = dat;
        MODE_I = mode;
    endtask

    // One-cycle strobe starting at the current negedge; write lands on the next edge.
    task automatic doWrite(input string tag, input logic [1:0] adr,
                           input logic [7:0] dat, input logic mode);
        applyStimulus(adr, dat, mode);
        stepTo(cyc + 1);
        checkOutput({tag, "_ack"}, 16'(ACK_O), 16'd1);
        STB_I = 1'b0;
        stepTo(cyc + 1);
        checkOutput({tag, "_ack_lo"}, 16'(ACK_O), 16'd0);
    endtask

    initial begin
        RST_I  = 1'b1;
        STB_I  = 1'b0;
        ADR_I  = 2'd0;
        DAT_I  = 8'h00;
        MODE_I = 1'b0;

        // Reset held for three edges.
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst1_ack",  16'(ACK_O),  16'd0);
        checkOutput("rst1_led",  16'(LED_O),  16'd0);
        checkOutput("rst1_busy", 16'(BUSY_O), 16'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ack",  16'(ACK_O),  16'd0);
        checkOutput("rst_led",  16'(LED_O),  16'd0);
        checkOutput("rst_busy", 16'(BUSY_O), 16'd0);
        RST_I = 1'b0;

        // Repeat pattern on channel 0, two passes expected.
        stepTo(32);
        pushPattern("rep_p1", 0, 40,  8'b10101000);
        pushPattern("rep_p2", 0, 168, 8'b10101000);
        doWrite("wr_rep", 2'd0, 8'b10101000, 1'b1);
        checkOutput("rep_busy_start", 16'(BUSY_O), 16'd1);

        // Double-buffered write at idx 3 of the second pass.
        stepTo(212);
        pushPattern("dbuf", 0, 296, 8'b11001010);
        doWrite("wr_dbuf", 2'd0, 8'b11001010, 1'b1);

        // Out-of-range address: acked, no channel changes.
        stepTo(324);
        doWrite("wr_badadr", 2'd3, 8'h3C, 1'b1);
        checkOutput("badadr_busy", 16'(BUSY_O), 16'd1);

        // Pending write, then a boundary-cycle write that must win over it.
        stepTo(372);
        doWrite("wr_pend", 2'd0, 8'h55, 1'b1);
        stepTo(415);
        pushPattern("coll", 0, 424, 8'hFF);
        pushIdle("coll_idle", 552);
        doWrite("wr_coll", 2'd0, 8'hFF, 1'b0);
        stepTo(556);

        // One-shot on channel 1 with a strobe held for 811 cycles.
        stepTo(560);
        ackBefore = ackSeen;
        pushPattern("oneshot", 1, 568, 8'hF0);
        pushIdle("oneshot_idle", 696);
        applyStimulus(2'd1, 8'hF0, 1'b0);
        stepTo(561);
        checkOutput("os_ack",       16'(ACK_O),  16'd1);
        checkOutput("os_led_lag",   16'(LED_O),  16'd0);
        checkOutput("os_busy",      16'(BUSY_O), 16'd2);
        stepTo(562);
        checkOutput("os_led_first", 16'(LED_O),  16'd2);
        checkOutput("os_ack_lo",    16'(ACK_O),  16'd0);
        stepTo(1371);
        STB_I = 1'b0;
        stepTo(1380);
        checkOutput("os_ack_count", 16'(ackSeen - ackBefore), 16'd1);
        checkOutput("os_end_busy",  16'(BUSY_O), 16'd0);

        // Both channels running, pending on channel 0, then reset at idx 4.
        stepTo(1392);
        doWrite("wr_r0", 2'd0, 8'hAA, 1'b1);
        doWrite("wr_r1", 2'd1, 8'h0F, 1'b1);
        stepTo(1428);
        doWrite("wr_r0_pend", 2'd0, 8'h33, 1'b0);
        stepTo(1464);
        checkOutput("pre_rst_led",  16'(LED_O),  16'd3);
        checkOutput("pre_rst_busy", 16'(BUSY_O), 16'd3);
        RST_I = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_ack",  16'(ACK_O),  16'd0);
        checkOutput("mid_rst_led",  16'(LED_O),  16'd0);
        checkOutput("mid_rst_busy", 16'(BUSY_O), 16'd0);
        RST_I = 1'b0;

        // Prescaler restarted: write at edge 15 must see its first tick at edge 16.
        stepTo(14);
        checkOutput("post_rst_busy", 16'(BUSY_O), 16'd0);
        applyStimulus(2'd0, 8'h80, 1'b0);
        stepTo(15);
        checkOutput("pr_ack",  16'(ACK_O),  16'd1);
        checkOutput("pr_busy", 16'(BUSY_O), 16'd1);
        checkOutput("pr_led0", 16'(LED_O),  16'd0);
        STB_I = 1'b0;
        stepTo(16);
        checkOutput("pr_led1", 16'(LED_O),  16'd1);
        stepTo(17);
        checkOutput("pr_led2", 16'(LED_O),  16'd0);
        stepTo(127);
        checkOutput("pr_busy_last", 16'(BUSY_O), 16'd1);
        stepTo(128);
        checkOutput("pr_busy_done", 16'(BUSY_O), 16'd0);

        checkOutput("sb_left", 16'(sb.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
